sisc_ctrl: RTL and testbench

//  Multi-cycle control unit for the SISC processor. Sequences each instruction through

---
 rtl/sisc_ctrl_if.sv | 29 ++
 rtl/sisc_ctrl.sv | 111 +++++++++++
 tb/tb_sisc_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sisc_ctrl_if.sv
// Control bundle between the SISC datapath (master) and the sisc_ctrl sequencer (slave).
interface sisc_ctrl_if;
  logic [3:0] OPCODE;
  logic [3:0] MM;
  logic [3:0] STAT;
  logic       RF_WE;
  logic [1:0] ALU_OP;
  logic       WB_SEL;
  logic       RD_SEL;
  logic       STAT_EN;
  logic       IR_LOAD;
  logic       PC_WRITE;
  logic       PC_SEL;
  logic       BR_SEL;
  logic       PC_RST;
  logic       HALTED;

  modport master (
    output OPCODE, MM, STAT,
    input  RF_WE, ALU_OP, WB_SEL, RD_SEL, STAT_EN, IR_LOAD,
           PC_WRITE, PC_SEL, BR_SEL, PC_RST, HALTED
  );

  modport slave (
    input  OPCODE, MM, STAT,
    output RF_WE, ALU_OP, WB_SEL, RD_SEL, STAT_EN, IR_LOAD,
           PC_WRITE, PC_SEL, BR_SEL, PC_RST, HALTED
  );
endinterface

// File: rtl/sisc_ctrl.sv
// SISC multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer.
// Define SISC_BRANCH_EN to enable BRA (4'h2) / BRR (4'h3) evaluation in DECODE.
module sisc_ctrl #(
  parameter logic [3:0]  ALU_OPC  = 4'h8,
  parameter logic [3:0]  HALT_OPC = 4'hF,
  parameter int unsigned IMM_BIT  = 3
) (
  input  logic      CLK,
  input  logic      RST_F,
  sisc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_alu;
  logic w_imm;
  logic w_branch;
  logic w_taken;
  logic w_abs;

  assign w_alu = (bus.OPCODE == ALU_OPC);
  assign w_imm = bus.MM[IMM_BIT];

`ifdef SISC_BRANCH_EN
  assign w_branch = (bus.OPCODE == 4'h2) || (bus.OPCODE == 4'h3);
  assign w_taken  = |(bus.STAT & bus.MM);
  assign w_abs    = (bus.OPCODE == 4'h2);
`else
  logic w_unused_br;
  assign w_unused_br = ^{bus.STAT, bus.MM};
  assign w_branch    = 1'b0;
  assign w_taken     = 1'b0;
  assign w_abs       = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) r_state <= S_START;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.RF_WE    = 1'b0;
    bus.ALU_OP   = 2'b00;
    bus.WB_SEL   = 1'b0;
    bus.RD_SEL   = 1'b0;
    bus.STAT_EN  = 1'b0;
    bus.IR_LOAD  = 1'b0;
    bus.PC_WRITE = 1'b0;
    bus.PC_SEL   = 1'b0;
    bus.BR_SEL   = 1'b0;
    bus.PC_RST   = 1'b0;
    bus.HALTED   = 1'b0;
    case (r_state)
      S_START: begin
        bus.PC_RST = 1'b1;
        w_next     = S_FETCH;
      end
      S_FETCH: begin
        bus.IR_LOAD  = 1'b1;
        bus.PC_WRITE = 1'b1;
        w_next       = S_DECODE;
      end
      S_DECODE: begin
        // PC_SEL/BR_SEL stay 0 unless the branch build recognises the opcode
        if (w_branch) begin
          bus.PC_SEL   = 1'b1;
          bus.PC_WRITE = w_taken;
          bus.BR_SEL   = w_abs;
          bus.ALU_OP   = 2'b10;
        end
        w_next = (bus.OPCODE == HALT_OPC) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        if (w_alu) begin
          bus.ALU_OP  = w_imm ? 2'b01 : 2'b00;
          bus.STAT_EN = 1'b1;
        end
        w_next = S_MEM;
      end
      S_MEM: begin
        if (w_alu) bus.ALU_OP = w_imm ? 2'b01 : 2'b00;
        w_next = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (w_alu) begin
          bus.ALU_OP = w_imm ? 2'b01 : 2'b00;
          bus.RF_WE  = 1'b1;
        end
        w_next = S_FETCH;
      end
      S_HALT: begin
        bus.HALTED = 1'b1;
        w_next     = S_HALT;
      end
      default: w_next = S_START;
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Randomized bench for sisc_ctrl against a per-instruction-phase behavioural model.
module tb_sisc_ctrl;

  logic clk;
  logic rst_f;

  sisc_ctrl_if bus ();

  sisc_ctrl #(
    .ALU_OPC (4'h8),
    .HALT_OPC(4'hF),
    .IMM_BIT (3)
  ) u_dut (
    .CLK  (clk),
    .RST_F(rst_f),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [3:0] mm;
    logic [3:0] st;
    bit         abort;
  } instr_t;

  instr_t q[$];
  instr_t cur;
  int     phase;      // -1 reset/start, 0..4 instruction clock, 5 halted
  int     halt_cnt;
  int     n_cmp;
  int     n_err;

  // {RF_WE, ALU_OP[1:0], WB_SEL, RD_SEL, STAT_EN, IR_LOAD, PC_WRITE, PC_SEL, BR_SEL, PC_RST, HALTED}
  function automatic logic [11:0] dut_vec();
    return {bus.RF_WE, bus.ALU_OP, bus.WB_SEL, bus.RD_SEL, bus.STAT_EN, bus.IR_LOAD,
            bus.PC_WRITE, bus.PC_SEL, bus.BR_SEL, bus.PC_RST, bus.HALTED};
  endfunction

  function automatic logic [11:0] model(int ph, logic [3:0] op, logic [3:0] mm, logic [3:0] st);
    logic       rf_we = 1'b0, stat_en = 1'b0, ir_load = 1'b0, pc_write = 1'b0;
    logic       pc_sel = 1'b0, br_sel = 1'b0, pc_rst = 1'b0, halted = 1'b0;
    logic [1:0] alu_op = 2'b00;
    bit         is_br;
`ifdef SISC_BRANCH_EN
    is_br = (op == 4'h2) || (op == 4'h3);
`else
    is_br = 1'b0;
`endif
    if (ph < 0) pc_rst = 1'b1;
    else if (ph == 0) begin
      ir_load  = 1'b1;
      pc_write = 1'b1;
    end else if (ph == 1) begin
      if (is_br) begin
        pc_sel   = 1'b1;
        pc_write = (st & mm) != 4'h0;
        br_sel   = (op == 4'h2);
        alu_op   = 2'b10;
      end
    end else if (ph <= 4) begin
      if (op == 4'h8) begin
        alu_op  = mm[3] ? 2'b01 : 2'b00;
        stat_en = (ph == 2);
        rf_we   = (ph == 4);
      end
    end else halted = 1'b1;
    return {rf_we, alu_op, 1'b0, 1'b0, stat_en, ir_load, pc_write, pc_sel, br_sel, pc_rst, halted};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (op=%h mm=%h st=%h phase=%0d t=%0t)",
               tag, got, exp, bus.OPCODE, bus.MM, bus.STAT, phase, $time);
    end
  endtask

  task automatic do_reset(input string tag);
    #1 rst_f = 1'b0;
    #1 check({tag, "_async"}, dut_vec(), model(-1, 4'h0, 4'h0, 4'h0));
    @(negedge clk);
    check({tag, "_held"}, dut_vec(), model(-1, 4'h0, 4'h0, 4'h0));
    rst_f = 1'b1;
    #1 check({tag, "_start"}, dut_vec(), model(-1, 4'h0, 4'h0, 4'h0));
    phase    = 0;
    halt_cnt = 0;
  endtask

  function automatic instr_t rand_instr();
    instr_t  t;
    int unsigned r = $urandom_range(0, 15);
    if (r < 6)       t.op = 4'h8;
    else if (r < 8)  t.op = 4'h0;
    else if (r < 10) t.op = 4'h2;
    else if (r < 12) t.op = 4'h3;
    else if (r == 12) t.op = 4'hF;
    else             t.op = 4'($urandom_range(0, 14));
    t.mm    = 4'($urandom_range(0, 15));
    t.st    = 4'($urandom_range(0, 15));
    t.abort = ($urandom_range(0, 9) == 0);
    return t;
  endfunction

  task automatic step();
    string tag;
    @(negedge clk);
    if (phase == 0) begin
      cur = (q.size() != 0) ? q.pop_front() : rand_instr();
      bus.OPCODE = cur.op;
      bus.MM     = cur.mm;
      bus.STAT   = cur.st;
    end
    #1;
    case (phase)
      0: tag = "fetch";
      1: tag = "decode";
      2: tag = "execute";
      3: tag = "mem";
      4: tag = "writeback";
      default: tag = "halt";
    endcase
    check(tag, dut_vec(), model(phase, cur.op, cur.mm, cur.st));
    if (phase == 2 && cur.abort) do_reset("rst_exec");
    else if (phase == 5) begin
      halt_cnt++;
      if (halt_cnt == 20) do_reset("rst_halt");
    end else if (phase == 1) phase = (cur.op == 4'hF) ? 5 : 2;
    else if (phase == 4) phase = 0;
    else phase = phase + 1;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    halt_cnt   = 0;
    phase      = -1;
    cur        = '{op: 4'h0, mm: 4'h0, st: 4'h0, abort: 1'b0};
    rst_f      = 1'b0;
    bus.OPCODE = 4'h0;
    bus.MM     = 4'h0;
    bus.STAT   = 4'h0;

    q.push_back('{op: 4'h8, mm: 4'h0, st: 4'h0, abort: 1'b0});  // ADD
    q.push_back('{op: 4'h8, mm: 4'h8, st: 4'h0, abort: 1'b0});  // ADDI
    q.push_back('{op: 4'h0, mm: 4'h0, st: 4'h0, abort: 1'b0});  // NOP
    q.push_back('{op: 4'h2, mm: 4'h1, st: 4'h1, abort: 1'b0});  // BRA taken
    q.push_back('{op: 4'h2, mm: 4'h8, st: 4'h1, abort: 1'b0});  // BRA not taken
    q.push_back('{op: 4'h3, mm: 4'h1, st: 4'h1, abort: 1'b0});  // BRR taken
    q.push_back('{op: 4'h8, mm: 4'h0, st: 4'h0, abort: 1'b1});  // reset in EXECUTE
    q.push_back('{op: 4'h8, mm: 4'h8, st: 4'h0, abort: 1'b0});
    q.push_back('{op: 4'hF, mm: 4'h0, st: 4'h0, abort: 1'b0});  // HALT

    #1 check("reset", dut_vec(), model(-1, 4'h0, 4'h0, 4'h0));
    #19 rst_f = 1'b1;
    #1 check("start", dut_vec(), model(-1, 4'h0, 4'h0, 4'h0));
    phase = 0;

    repeat (2000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
